// File: rtl/oam_dma_engine.sv
// OAM DMA engine: after a CPU write to P_REG_ADDR it copies P_LENGTH bytes from
// {src_hi,8'h00} to P_DEST_BASE, mastering the shared memory bus through REQ/GNT.
module oam_dma_engine #(
   parameter logic [15:0] P_REG_ADDR  = 16'hFF46,
   parameter logic [15:0] P_DEST_BASE = 16'hFE00,
   parameter logic [7:0]  P_LENGTH    = 8'd160
) (
   input  logic        I_CLK,
   input  logic        I_RESET_L,
   input  logic [15:0] I_ADDR,
   inout  wire  [7:0]  IO_DATA,
   input  logic        I_WE_L,
   input  logic        I_RE_L,
   output logic        O_BUS_REQ,
   input  logic        I_BUS_GNT,
   output logic [15:0] O_DMA_ADDR,
   output logic        O_DMA_RE_L,
   output logic        O_DMA_WE_L,
   output logic [7:0]  O_DMA_DOUT,
   input  logic [7:0]  I_DMA_DIN,
   output logic        O_DMA_BUSY
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RD,
      S_CAP,
      S_WR
   } state_t;

   state_t      state;
   logic [7:0]  src_hi;
   logic [7:0]  idx;
   logic [7:0]  idx_next;
   logic        rd_en;
   logic        reg_sel;
   logic        reg_wr;

   assign reg_sel  = (I_ADDR == P_REG_ADDR);
   assign reg_wr   = reg_sel && !I_WE_L;
   assign idx_next = idx + 8'd1;

   // A retrigger owns the cycle: the old transfer must not land a strobe alongside it.
   assign O_DMA_RE_L = !((state == S_RD) && I_BUS_GNT && !reg_wr);
   assign O_DMA_WE_L = !((state == S_WR) && I_BUS_GNT && !reg_wr);

   assign IO_DATA = rd_en ? src_hi : 8'hzz;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge I_CLK or negedge I_RESET_L) begin
      if (!I_RESET_L) begin
         state      <= S_IDLE;
         src_hi     <= 8'h00;
         idx        <= 8'h00;
         rd_en      <= 1'b0;
         O_BUS_REQ  <= 1'b0;
         O_DMA_BUSY <= 1'b0;
         O_DMA_ADDR <= 16'h0000;
         O_DMA_DOUT <= 8'h00;
      end else begin
         rd_en <= reg_sel && !I_RE_L;
         if (reg_wr) begin
            src_hi     <= IO_DATA;
            idx        <= 8'h00;
            state      <= S_REQ;
            O_BUS_REQ  <= 1'b1;
            O_DMA_BUSY <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  O_BUS_REQ  <= 1'b0;
                  O_DMA_BUSY <= 1'b0;
               end
               S_REQ: begin
                  if (I_BUS_GNT) begin
                     O_DMA_ADDR <= {src_hi, idx};
                     state      <= S_RD;
                  end
               end
               S_RD: begin
                  if (I_BUS_GNT) begin
                     state <= S_CAP;
                  end
               end
               S_CAP: begin
                  O_DMA_DOUT <= I_DMA_DIN;
                  O_DMA_ADDR <= P_DEST_BASE + {8'h00, idx};
                  state      <= S_WR;
               end
               S_WR: begin
                  if (I_BUS_GNT) begin
                     if (idx == P_LENGTH - 8'd1) begin
                        state      <= S_IDLE;
                        O_BUS_REQ  <= 1'b0;
                        O_DMA_BUSY <= 1'b0;
                     end else begin
                        idx        <= idx_next;
                        O_DMA_ADDR <= {src_hi, idx_next};
                        state      <= S_RD;
                     end
                  end
               end
               default: begin
                  state      <= S_IDLE;
                  O_BUS_REQ  <= 1'b0;
                  O_DMA_BUSY <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: a transaction-queue model of the expected bus operations,
// checked every cycle, plus directed scenarios with hand-computed timings and data.
module tb_oam_dma_engine;

   localparam logic [15:0] REG_ADDR = 16'hFF46;
   localparam logic [15:0] DEST     = 16'hFE00;
   localparam int          LEN      = 160;

   typedef struct packed {
      logic        is_wr;
      logic [15:0] addr;
      logic [7:0]  data;
   } op_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic        cpu_we_l = 1'b1;
   logic        cpu_re_l = 1'b1;
   logic        gnt = 1'b0;
   logic        tb_drive = 1'b0;
   logic [7:0]  tb_data = 8'h00;
   logic [7:0]  dma_din = 8'h00;
   wire  [7:0]  io_data;
   logic        bus_req;
   logic [15:0] dma_addr;
   logic        dma_re_l;
   logic        dma_we_l;
   logic [7:0]  dma_dout;
   logic        busy;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   op_t  exp_q[$];
   bit   exp_busy = 1'b0;
   bit   done_pending = 1'b0;
   logic [7:0] oam [0:255];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Released CPU data bus reads back as 8'hFF.
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (io_data[g]);
   end
   assign io_data = tb_drive ? tb_data : 8'hzz;

   oam_dma_engine dut (
      .I_CLK      (clk),
      .I_RESET_L  (rst_n),
      .I_ADDR     (cpu_addr),
      .IO_DATA    (io_data),
      .I_WE_L     (cpu_we_l),
      .I_RE_L     (cpu_re_l),
      .O_BUS_REQ  (bus_req),
      .I_BUS_GNT  (gnt),
      .O_DMA_ADDR (dma_addr),
      .O_DMA_RE_L (dma_re_l),
      .O_DMA_WE_L (dma_we_l),
      .O_DMA_DOUT (dma_dout),
      .I_DMA_DIN  (dma_din),
      .O_DMA_BUSY (busy)
   );

   function automatic logic [7:0] src_byte(input logic [15:0] a);
      logic [7:0] m;
      m = 8'(a[7:0] * 8'd7);
      return m + a[15:8];
   endfunction

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Source memory: registered read, data valid the cycle after RE_L low.
   always @(posedge clk) begin
      if (!dma_re_l) dma_din <= src_byte(dma_addr);
      if (!dma_we_l && dma_addr[15:8] == DEST[15:8]) oam[dma_addr[7:0]] <= dma_dout;
   end

   // Model: a trigger schedules the full list of reads and writes for the new source page.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_busy = 1'b0;
         done_pending = 1'b0;
      end else if (!cpu_we_l && cpu_addr == REG_ADDR) begin
         exp_q.delete();
         for (int i = 0; i < LEN; i++) begin
            exp_q.push_back('{1'b0, {tb_data, 8'(i)}, 8'h00});
            exp_q.push_back('{1'b1, DEST + 16'(i), src_byte({tb_data, 8'(i)})});
         end
         exp_busy = 1'b1;
         done_pending = 1'b0;
      end else if (done_pending) begin
         exp_busy = 1'b0;
         done_pending = 1'b0;
      end
   end

   always @(negedge clk) begin
      op_t op;
      if (rst_n) begin
         check("both_strobes", !(!dma_re_l && !dma_we_l), 32'({dma_re_l, dma_we_l}), 32'h3);
         check("strobe_no_gnt", gnt || (dma_re_l && dma_we_l), 32'({dma_re_l, dma_we_l}), 32'h3);
         if (!cpu_we_l && cpu_addr == REG_ADDR)
            check("retrig_strobe", dma_re_l && dma_we_l, 32'({dma_re_l, dma_we_l}), 32'h3);
         check("req", bus_req == exp_busy, 32'(bus_req), 32'(exp_busy));
         check("busy", busy == exp_busy, 32'(busy), 32'(exp_busy));
         if (!dma_re_l || !dma_we_l) begin
            if (exp_q.size() == 0) begin
               check("unexpected_op", 1'b0, 32'(dma_addr), 32'h0);
            end else begin
               op = exp_q.pop_front();
               check("op_kind", op.is_wr == !dma_we_l, 32'(!dma_we_l), 32'(op.is_wr));
               check("op_addr", dma_addr == op.addr, 32'(dma_addr), 32'(op.addr));
               if (op.is_wr) check("op_data", dma_dout == op.data, 32'(dma_dout), 32'(op.data));
               if (exp_q.size() == 0) done_pending = 1'b1;
            end
         end
      end
   end

   task automatic set_gnt(input logic v);
      @(posedge clk); #2;
      gnt = v;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      @(posedge clk); #2;
      cpu_addr = a; tb_data = d; tb_drive = 1'b1; cpu_we_l = 1'b0;
      @(posedge clk); #2;
      cpu_we_l = 1'b1; tb_drive = 1'b0;
   endtask

   task automatic wait_rd_addr(input string name, input logic [15:0] a, input int limit);
      bit found = 1'b0;
      for (int i = 0; i < limit && !found; i++) begin
         @(negedge clk);
         found = !dma_re_l && dma_addr == a;
      end
      check(name, found, 32'(dma_addr), 32'(a));
   endtask

   task automatic wait_strobe(input string name, input bit want_wr, input int limit);
      bit found = 1'b0;
      for (int i = 0; i < limit && !found; i++) begin
         @(negedge clk);
         found = want_wr ? !dma_we_l : !dma_re_l;
      end
      check(name, found, 32'(found), 32'h1);
   endtask

   task automatic wait_busy_low(input string name, input int limit, output int t);
      bit found = 1'b0;
      for (int i = 0; i < limit && !found; i++) begin
         @(negedge clk);
         found = !busy;
      end
      t = cyc;
      check(name, found, 32'(busy), 32'h0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},  bus_req == 1'b0,   32'(bus_req),  32'h0);
      check({tag, "_re"},   dma_re_l == 1'b1,  32'(dma_re_l), 32'h1);
      check({tag, "_we"},   dma_we_l == 1'b1,  32'(dma_we_l), 32'h1);
      check({tag, "_addr"}, dma_addr == 16'h0, 32'(dma_addr), 32'h0);
      check({tag, "_dout"}, dma_dout == 8'h0,  32'(dma_dout), 32'h0);
      check({tag, "_busy"}, busy == 1'b0,      32'(busy),     32'h0);
      check({tag, "_io"},   io_data == 8'hFF,  32'(io_data),  32'hFF);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      int t1;
      int tr;
      int bad;

      #1;
      check_reset_outputs("rst0");
      #20 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // 1: continuous grant, page C1
      set_gnt(1'b1);
      cpu_write(REG_ADDR, 8'hC1);
      t0 = cyc;
      wait_strobe("t1_first_rd", 1'b0, 20);
      tr = cyc;
      check("t1_first_rd_addr", dma_addr == 16'hC100, 32'(dma_addr), 32'hC100);
      wait_busy_low("t1_busy_fall", 2000, t1);
      check("t1_req_to_idle", t1 - t0 == 481, 32'(t1 - t0), 32'd481);
      check("t1_rd_to_idle", t1 - tr == 480, 32'(t1 - tr), 32'd480);
      check("t1_oam0", oam[0] == 8'hC1, 32'(oam[0]), 32'hC1);
      check("t1_oam159", oam[159] == 8'h1A, 32'(oam[159]), 32'h1A);
      bad = 0;
      for (int i = 0; i < LEN; i++) if (oam[i] != src_byte({8'hC1, 8'(i)})) bad++;
      check("t1_oam_all", bad == 0, 32'(bad), 32'h0);
      check("t1_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'h0);

      // 2: grant withheld for the first 5 REQ cycles
      set_gnt(1'b0);
      cpu_write(REG_ADDR, 8'hC2);
      t0 = cyc;
      repeat (5) @(posedge clk);
      #2 gnt = 1'b1;
      wait_busy_low("t2_busy_fall", 2000, t1);
      check("t2_req_to_idle", t1 - t0 == 486, 32'(t1 - t0), 32'd486);
      check("t2_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'h0);

      // 3: grant dropped for 3 WR cycles at byte 50
      cpu_write(REG_ADDR, 8'h20);
      t0 = cyc;
      wait_rd_addr("t3_rd50", 16'h2032, 400);
      @(posedge clk); #2 gnt = 1'b0;
      repeat (4) @(posedge clk);
      #2 gnt = 1'b1;
      wait_busy_low("t3_busy_fall", 2000, t1);
      check("t3_req_to_idle", t1 - t0 == 484, 32'(t1 - t0), 32'd484);
      check("t3_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'h0);

      // 4: retrigger to page D0 during the WR of byte 80
      cpu_write(REG_ADDR, 8'h55);
      wait_rd_addr("t4_rd80", 16'h5550, 400);
      @(posedge clk);
      cpu_write(REG_ADDR, 8'hD0);
      t0 = cyc;
      wait_strobe("t4_rd_after", 1'b0, 20);
      check("t4_rd_addr", dma_addr == 16'hD000, 32'(dma_addr), 32'hD000);
      wait_strobe("t4_wr_after", 1'b1, 20);
      check("t4_wr_addr", dma_addr == 16'hFE00, 32'(dma_addr), 32'hFE00);
      check("t4_wr_data", dma_dout == 8'hD0, 32'(dma_dout), 32'hD0);
      wait_busy_low("t4_busy_fall", 2000, t1);
      check("t4_req_to_idle", t1 - t0 == 481, 32'(t1 - t0), 32'd481);
      check("t4_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'h0);

      // 6: register readback with one-cycle latency
      set_gnt(1'b0);
      cpu_write(REG_ADDR, 8'h3A);
      @(posedge clk); #2 cpu_addr = REG_ADDR; cpu_re_l = 1'b0;
      @(negedge clk);
      check("t6_rd_same_cycle", io_data == 8'hFF, 32'(io_data), 32'hFF);
      @(posedge clk); #2 cpu_re_l = 1'b1;
      @(negedge clk);
      check("t6_rd_data", io_data == 8'h3A, 32'(io_data), 32'h3A);
      @(posedge clk); #2 cpu_addr = 16'h1234; cpu_re_l = 1'b0;
      @(negedge clk);
      check("t6_released", io_data == 8'hFF, 32'(io_data), 32'hFF);
      @(posedge clk); #2 cpu_re_l = 1'b1;
      @(negedge clk);
      check("t6_unselected", io_data == 8'hFF, 32'(io_data), 32'hFF);

      // 5: reset at byte 20 of the pending 3A transfer
      set_gnt(1'b1);
      wait_rd_addr("t5_rd20", 16'h3A14, 200);
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("t5_rst");
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("t5_idle_busy", busy == 1'b0, 32'(busy), 32'h0);
      check("t5_idle_req", bus_req == 1'b0, 32'(bus_req), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
